// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types and constants for the iterative CORDIC
//                sequencer: FSM encoding, iteration limit, the arctangent
//                table (2^32 = 2*pi) and the gain-compensation constant.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest iteration count the 5-bit counter and atan table can serve.
  localparam int ITER_MAX = 31;
  localparam int CNT_W    = $clog2(ITER_MAX + 1);

  // round(atan(2^-i) * 2^32 / (2*pi)), i = 0..31.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  // CORDIC gain compensation 0.6072529350 in Q1.31.
  localparam logic [31:0] CORDIC_GAIN_Q31 = 32'd1304065748;

  // Initial x for a given width: gain scaled to 2^(width-2) full scale.
  function automatic int k_init_for(input int width);
    return int'(CORDIC_GAIN_Q31 >> (33 - width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_atan_rom
//  Description : Combinational arctangent lookup. Returns atan(2^-idx)
//                scaled to 2^WIDTH = 2*pi, derived from the 32-bit package
//                table with round-half-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [CNT_W-1:0] idx,
  output logic [WIDTH-1:0] atan_o
);

  localparam int SHIFT = 32 - WIDTH;

  logic [31:0] raw;

  assign raw = ATAN_TABLE[idx];

  generate
    if (SHIFT > 0) begin : g_round
      // Add half an output LSB before dropping the low bits.
      assign atan_o = WIDTH'(({1'b0, raw} + (33'd1 << (SHIFT - 1))) >> SHIFT);
    end else begin : g_exact
      assign atan_o = raw[WIDTH-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_seq_ctrl
//  Description : Iterative CORDIC sequencer. Accepts one phase word, folds
//                it into +/-pi/2, runs ITER rotations on a single shared
//                datapath and returns sine/cosine over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int ITER   = 22,
  parameter int K_INIT = k_init_for(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        phase_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] sin_o,
  output logic signed [WIDTH-1:0] cos_o,
  output logic                    busy_o
);

  localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(ITER - 1);
  localparam logic [WIDTH-1:0]        HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] X_INIT    = WIDTH'(K_INIT);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic signed [WIDTH-1:0] z;
  logic                    fold;
  logic                    phase_fold;
  logic                    accept;
  logic                    last_iter;
  logic [WIDTH-1:0]        atan_i;
  logic signed [WIDTH-1:0] x_shr;
  logic signed [WIDTH-1:0] y_shr;
  logic signed [WIDTH-1:0] x_nxt;
  logic signed [WIDTH-1:0] y_nxt;
  logic signed [WIDTH-1:0] z_nxt;

  assign in_ready   = (state == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_iter  = (cnt == LAST_CNT);
  // Second and third quadrants are rotated by pi and negated at the output.
  assign phase_fold = phase_i[WIDTH-1] ^ phase_i[WIDTH-2];

  cordic_atan_rom #(
    .WIDTH (WIDTH)
  ) u_atan_rom (
    .idx    (cnt),
    .atan_o (atan_i)
  );

  assign x_shr = x >>> cnt;
  assign y_shr = y >>> cnt;

  // One rotation step; direction follows the sign of the residual angle.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (z[WIDTH-1]) begin
      x_nxt = x + y_shr;
      y_nxt = y - x_shr;
      z_nxt = z + $signed(atan_i);
    end else begin
      x_nxt = x - y_shr;
      y_nxt = y + x_shr;
      z_nxt = z - $signed(atan_i);
    end
  end

  // Next-state logic for the accept / iterate / hand-off sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Iteration registers, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      cnt       <= '0;
      fold      <= 1'b0;
      sin_o     <= '0;
      cos_o     <= '0;
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      out_valid <= (state_next == ST_DONE);
      busy_o    <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x    <= X_INIT;
            y    <= '0;
            cnt  <= '0;
            fold <= phase_fold;
            z    <= phase_fold ? (phase_i ^ HALF_TURN) : phase_i;
          end
        end
        ST_RUN: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          if (last_iter) begin
            // Counter holds at the last index; results captured here.
            cos_o <= fold ? -x_nxt : x_nxt;
            sin_o <= fold ? -y_nxt : y_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cordic_seq_ctrl
//  Description : Self-checking bench for cordic_seq_ctrl with a result
//                scoreboard fed at each accept and drained at each hand-off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_seq_ctrl;

  localparam int  WIDTH  = 24;
  localparam int  ITER   = 22;
  localparam real TWO_PI = 6.283185307179586;
  localparam real FS     = 4194304.0;
  localparam int  TOL    = 32;

  typedef struct packed {
    logic [WIDTH-1:0] phase;
    int               es;
    int               ec;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] phase_i = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sin_o;
  logic [WIDTH-1:0] cos_o;
  logic             busy_o;

  exp_t sb[$];
  exp_t mon_e;
  real  th;
  int   tests = 0;
  int   fails = 0;
  int   accepts = 0;
  int   results = 0;
  int   abandoned = 0;

  cordic_seq_ctrl #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase_i   (phase_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sin_o     (sin_o),
    .cos_o     (cos_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [WIDTH-1:0] obs, input int exp);
    int o;
    int d;
    o = int'($signed(obs));
    d = o - exp;
    tests++;
    assert ((d <= TOL) && (d >= -TOL)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, o, exp, TOL);
    end
  endtask

  // Scoreboard: push the float model at accept, compare at hand-off.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      th          = real'(phase_i) * TWO_PI / 16777216.0;
      mon_e.phase = phase_i;
      mon_e.es    = $rtoi($sin(th) * FS);
      mon_e.ec    = $rtoi($cos(th) * FS);
      sb.push_back(mon_e);
      accepts++;
    end
    if (!rst && out_valid && out_ready) begin
      results++;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow: observed result with %0d pending expected >0", sb.size());
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_tol("sin", sin_o, mon_e.es);
        check_tol("cos", cos_o, mon_e.ec);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] p, input bit rnd);
    int lim;
    lim = 0;
    while (!in_ready && lim < 1000) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      lim++;
    end
    tests++;
    assert (in_ready === 1'b1) else begin
      fails++;
      $error("FAIL send_wait: observed in_ready %0b expected 1", in_ready);
    end
    phase_i  = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int lim;
    lim = 0;
    while (results != accepts - abandoned && lim < 500) begin
      @(posedge clk); #1;
      lim++;
    end
    check("drain", 32'(results), 32'(accepts - abandoned));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    bit saw;
    logic [WIDTH-1:0] snap_s;
    logic [WIDTH-1:0] snap_c;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_sin", 32'(sin_o), 0);
    check("rst_cos", 32'(cos_o), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Latency with phase 0, counted from the accept edge inclusive
    out_ready = 1'b1;
    send(24'd0, 1'b0);
    n = 1;
    check("run_busy", 32'(busy_o), 1);
    check("run_in_ready", 32'(in_ready), 0);
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(ITER + 1));
    check("done_busy", 32'(busy_o), 1);
    wait_done();
    check("accepts_first", 32'(accepts), 1);

    // Quadrant corners and fold path
    send(24'd4194304, 1'b0);  wait_done();
    send(24'd12582912, 1'b0); wait_done();
    send(24'd8388608, 1'b0);  wait_done();
    send(24'd2097152, 1'b0);  wait_done();

    // Back-pressure stall in DONE
    out_ready = 1'b0;
    send(24'd5000000, 1'b0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid", 32'(out_valid), 1);
    snap_s = sin_o;
    snap_c = cos_o;
    acc0   = accepts;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      phase_i  = WIDTH'($urandom);
      @(posedge clk); #1;
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_sin", 32'(snap_s), 32'(sin_o));
      check("stall_cos", 32'(snap_c), 32'(cos_o));
    end
    check("stall_no_accept", 32'(accepts), 32'(acc0));
    in_valid  = 1'b1;
    phase_i   = 24'd777777;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_no_bypass", 32'(accepts), 32'(acc0));
    check("handoff_busy", 32'(busy_o), 0);
    check("handoff_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_accept", 32'(accepts), 32'(acc0 + 1));
    check("next_busy", 32'(busy_o), 1);
    wait_done();

    // Reset while RUN with cnt == 5 abandons the transaction
    send(24'd3000000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    abandoned += sb.size();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("abandon_no_valid", 32'(saw), 0);
    check("abandon_busy", 32'(busy_o), 0);
    send(24'd0, 1'b0);
    wait_done();

    // Random sweep with random back-pressure
    for (int t = 0; t < 1000; t++) send(WIDTH'($urandom), 1'b1);
    out_ready = 1'b1;
    wait_done();
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
